// File: rtl/uart_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// uart_cmd_dispatch
//
// Purpose:
//   Parses framed commands out of a UART receiver byte stream and writes a
//   32-bit payload to one of NUM_CH destination channels.
//
//   Frame layout (one byte per receiver strobe):
//     0x4B, 0x4C, CH, D0, D1, D2, D3, CS
//   Payload is little-endian {D3,D2,D1,D0}. CS must equal CH^D0^D1^D2^D3 and
//   CH must be below NUM_CH, otherwise the frame is rejected.
//
// Optional feature:
//   UART_CMD_TIMEOUT_EN - when defined, a partial frame is abandoned after
//   TIMEOUT_CYC clk_50m cycles without a new byte. Abandoning after the
//   header has been seen counts as a rejected frame. When undefined there is
//   no timeout counter and a partial frame waits indefinitely.
//
// Ports:
//   clk_50m    in   1       system clock, 50 MHz
//   rst_n      in   1       asynchronous active-low reset
//   rx_done    in   1       receiver byte-valid level
//   rx_data    in   8       received byte, stable while rx_done is high
//   ch_data    out  32      payload of the last committed frame
//   ch_wr      out  NUM_CH  one-hot write strobe, one cycle per commit
//   busy       out  1       high whenever the parser is not hunting for 0x4B
//   frame_err  out  1       one-cycle pulse on a rejected frame
//   err_cnt    out  8       rejected-frame count, saturates at 255
//   state_dbg  out  4       current parser state, for observation only
// ---------------------------------------------------------------------------
module uart_cmd_dispatch #(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic [31:0]       ch_data,
    output logic [NUM_CH-1:0] ch_wr,
    output logic              busy,
    output logic              frame_err,
    output logic [7:0]        err_cnt,
    output logic [3:0]        state_dbg
);

    // Reject impossible configurations at elaboration.
    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_cmd_dispatch: NUM_CH must be 1..8 and TIMEOUT_CYC >= 1");
    end

    localparam logic [7:0] SYNC0    = 8'h4B;
    localparam logic [7:0] SYNC1    = 8'h4C;
    localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

    typedef enum logic [3:0] {
        S_HUNT_H0 = 4'd0,
        S_HUNT_H1 = 4'd1,
        S_CH      = 4'd2,
        S_D0      = 4'd3,
        S_D1      = 4'd4,
        S_D2      = 4'd5,
        S_D3      = 4'd6,
        S_CS      = 4'd7,
        S_COMMIT  = 4'd8
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        rx_done_q;
    logic        accept;
    logic [7:0]  ch_q;
    logic [31:0] data_sr;
    logic [7:0]  cs_acc;
    logic        frame_ok;
    logic        frame_bad;
    logic        to_hit;

    // Receiver handshake: there is no ready/backpressure. The receiver raises
    // rx_done with rx_data stable; exactly one byte is taken on the cycle the
    // level first rises, however long it stays high afterwards.
    assign accept = rx_done & ~rx_done_q;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;

    // Idle cycles since the last accepted byte while a frame is open. COMMIT
    // is a single-cycle drain state and never times out.
    assign to_hit = !accept
                    && (state != S_HUNT_H0)
                    && (state != S_COMMIT)
                    && (to_cnt == TO_LAST);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (accept || !busy || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HUNT_H0;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state and frame verdict ----------------
    always_comb begin
        state_nx  = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            S_HUNT_H0: begin
                if (accept && rx_data == SYNC0) state_nx = S_HUNT_H1;
            end
            S_HUNT_H1: begin
                if (accept) begin
                    if (rx_data == SYNC1) begin
                        state_nx = S_CH;
                    end else if (rx_data == SYNC0) begin
                        // A repeated first sync byte may itself start the frame.
                        state_nx = S_HUNT_H1;
                    end else begin
                        state_nx = S_HUNT_H0;
                    end
                end
            end
            S_CH: if (accept) state_nx = S_D0;
            S_D0: if (accept) state_nx = S_D1;
            S_D1: if (accept) state_nx = S_D2;
            S_D2: if (accept) state_nx = S_D3;
            S_D3: if (accept) state_nx = S_CS;
            S_CS: begin
                if (accept) begin
                    if (cs_acc == rx_data && ch_q < NUM_CH_B) begin
                        state_nx = S_COMMIT;
                        frame_ok = 1'b1;
                    end else begin
                        state_nx  = S_HUNT_H0;
                        frame_bad = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                // The commit cycle already behaves as the hunt state so a
                // byte arriving here is not lost.
                state_nx = (accept && rx_data == SYNC0) ? S_HUNT_H1 : S_HUNT_H0;
            end
            default: state_nx = S_HUNT_H0;
        endcase

        // Timeout only fires with no accept this cycle, so it never competes
        // with a checksum verdict. Losing sync after only the header bytes is
        // not treated as a broken frame.
        if (to_hit) begin
            state_nx  = S_HUNT_H0;
            frame_bad = (state != S_HUNT_H1);
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state != S_HUNT_H0);
        state_dbg = state;
        ch_wr     = '0;
        if (state == S_COMMIT) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_wr[i] = (ch_q == 8'(i));
            end
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q <= 1'b0;
            ch_q      <= '0;
            data_sr   <= '0;
            cs_acc    <= '0;
            ch_data   <= '0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            rx_done_q <= rx_done;
            frame_err <= frame_bad;

            // frame_bad is a single flag, so coincident causes count once.
            if (frame_bad && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end

            // Loaded on the edge into COMMIT; held otherwise.
            if (frame_ok) begin
                ch_data <= data_sr;
            end

            if (accept) begin
                case (state)
                    S_CH: begin
                        ch_q   <= rx_data;
                        cs_acc <= rx_data;
                    end
                    S_D0, S_D1, S_D2, S_D3: begin
                        // Shift in from the top: after D3 the register
                        // holds {D3,D2,D1,D0}.
                        data_sr <= {rx_data, data_sr[31:8]};
                        cs_acc  <= cs_acc ^ rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_dispatch
//
// Drives byte streams into uart_cmd_dispatch and compares every observable
// output after each byte against a byte-queue model of the framing rules.
// ---------------------------------------------------------------------------
module tb_uart_cmd_dispatch;

  localparam int NUM_CH      = 4;
  localparam int TIMEOUT_CYC = 64;

  // ---------------- clock / reset ----------------
  logic              clk_50m = 1'b0;
  logic              rst_n   = 1'b0;
  logic              rx_done = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [31:0]       ch_data;
  logic [NUM_CH-1:0] ch_wr;
  logic              busy;
  logic              frame_err;
  logic [7:0]        err_cnt;
  logic [3:0]        state_dbg;

  always #10 clk_50m = ~clk_50m;

  uart_cmd_dispatch #(
    .NUM_CH      (NUM_CH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .ch_data   (ch_data),
    .ch_wr     (ch_wr),
    .busy      (busy),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int          vectors = 0;
  int          fails   = 0;
  logic [7:0]  mbuf[$];      // bytes of the frame currently being collected
  logic [31:0] m_data = '0;  // last committed payload
  int          m_err  = 0;   // rejected frames, saturating

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feed one byte to the model; returns the write strobe and error pulse
  // the byte should produce on the following cycle.
  task automatic model_byte(input logic [7:0] b, output logic [NUM_CH-1:0] wr,
                            output logic err);
    logic [7:0] cs;
    int         ch;
    wr  = '0;
    err = 1'b0;
    if (mbuf.size() == 0) begin
      if (b == 8'h4B) mbuf.push_back(b);
    end else if (mbuf.size() == 1) begin
      if (b == 8'h4C) mbuf.push_back(b);
      else if (b != 8'h4B) mbuf.delete();
    end else begin
      mbuf.push_back(b);
      if (mbuf.size() == 8) begin
        cs = mbuf[2] ^ mbuf[3] ^ mbuf[4] ^ mbuf[5] ^ mbuf[6];
        ch = int'(mbuf[2]);
        if (cs == mbuf[7] && ch < NUM_CH) begin
          wr[ch] = 1'b1;
          m_data = {mbuf[6], mbuf[5], mbuf[4], mbuf[3]};
        end else begin
          err = 1'b1;
          if (m_err < 255) m_err++;
        end
        mbuf.delete();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    logic [NUM_CH-1:0] ewr;
    logic              eerr;
    logic              ebusy;
    @(negedge clk_50m);
    rx_data = b;
    rx_done = 1'b1;
    model_byte(b, ewr, eerr);
    ebusy = (mbuf.size() != 0) || (ewr != '0);
    @(negedge clk_50m);
    check("ch_wr",     32'(ch_wr),     32'(ewr));
    check("frame_err", 32'(frame_err), 32'(eerr));
    check("busy",      32'(busy),      32'(ebusy));
    check("ch_data",   ch_data,        m_data);
    check("err_cnt",   32'(err_cnt),   32'(m_err));
    // Holding the level must not produce another byte.
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk_50m);
      check("hold_ch_wr",     32'(ch_wr),     32'd0);
      check("hold_frame_err", 32'(frame_err), 32'd0);
      check("hold_busy",      32'(busy),      32'(mbuf.size() != 0));
    end
    rx_done = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk_50m);
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [31:0] d, input logic [7:0] cs);
    send_byte(8'h4B);
    send_byte(8'h4C);
    send_byte(ch);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte(d[23:16]);
    send_byte(d[31:24]);
    send_byte(cs);
  endtask

  task automatic do_reset();
    @(negedge clk_50m);
    rst_n   = 1'b0;
    rx_done = 1'b0;
    mbuf.delete();
    m_data = '0;
    m_err  = 0;
    @(negedge clk_50m);
    check("rst_ch_data",   ch_data,        32'd0);
    check("rst_ch_wr",     32'(ch_wr),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    @(negedge clk_50m);
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation exceeded 80000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0]  ch;
    logic [31:0] d;
    logic [7:0]  cs;
    logic        seen;

    do_reset();

    // Reference frame.
    send_frame(8'h01, 32'h12345678, 8'h09);
    check("ref_ch_data", ch_data, 32'h12345678);

    // Same frame with wrong checksum.
    send_frame(8'h01, 32'h12345678, 8'h00);
    check("badcs_err_cnt", 32'(err_cnt), 32'd1);
    check("badcs_ch_data", ch_data, 32'h12345678);

    // Out-of-range channel with a valid checksum.
    send_frame(8'h05, 32'h00000000, 8'h05);
    check("badch_err_cnt", 32'(err_cnt), 32'd2);

    // Leading garbage and a repeated first sync byte.
    send_byte(8'h00);
    send_byte(8'h4B);
    send_frame(8'h03, 32'h00000001, 8'h02);
    check("garbage_ch_data", ch_data, 32'h00000001);

    // Randomized frames, some corrupted, some preceded by a stray byte.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)));
      ch = 8'($urandom_range(0, 7));
      d  = $urandom;
      cs = ch ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      send_frame(ch, d, cs);
    end

    // Stall mid-frame after the channel byte.
    send_byte(8'h4B);
    send_byte(8'h4C);
    send_byte(8'h02);
    seen = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_CYC + 20 && !seen; i++) begin
      @(negedge clk_50m);
      if (frame_err) seen = 1'b1;
    end
    mbuf.delete();
    if (m_err < 255) m_err++;
    check("timeout_err_seen", 32'(seen), 32'd1);
    check("timeout_busy",     32'(busy), 32'd0);
    check("timeout_err_cnt",  32'(err_cnt), 32'(m_err));
`else
    for (int i = 0; i < TIMEOUT_CYC + 20; i++) begin
      @(negedge clk_50m);
      if (frame_err) seen = 1'b1;
    end
    check("stall_no_err",  32'(seen), 32'd0);
    check("stall_busy",    32'(busy), 32'd1);
`endif

    // Reset in the middle of a frame, then a clean frame.
    do_reset();
    send_byte(8'h4B);
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h56);
    do_reset();
    send_frame(8'h01, 32'h12345678, 8'h09);
    check("post_rst_ch_data", ch_data, 32'h12345678);
    check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

    // Saturation of the error counter.
    for (int f = 0; f < 300; f++) begin
      send_frame(8'h00, 32'h00000000, 8'hFF);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_dispatch.md
UART_CMD_DISPATCH -- requirements
Module: uart_cmd_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of 32-bit destination channels (1..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, inter-byte timeout in clk_50m cycles (1 ms).
REQ-003 SHALL have port clk_50m  input  1  system clock, 50 MHz.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_done  input  1  receiver byte-valid level; a byte is accepted on its rising edge only.
REQ-006 SHALL have port rx_data  input  8  received byte, stable while rx_done is high.
REQ-007 SHALL have port ch_data  output  32  payload of the last committed frame.
REQ-008 SHALL have port ch_wr  output  NUM_CH  one-hot write strobe, one cycle per commit.
REQ-009 SHALL have port busy  output  1  high whenever state is not HUNT_H0.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.
REQ-011 SHALL have port err_cnt  output  8  rejected-frame count, saturating.

Function
REQ-012 SHALL register rx_done once; accept = rx_done & ~rx_done_q; a level held high SHALL yield exactly one accept.
REQ-013 SHALL frame as: 0x4B, 0x4C, CH, D0, D1, D2, D3, CS; payload little-endian {D3,D2,D1,D0}.
REQ-014 SHALL use states HUNT_H0, HUNT_H1, CH, D0, D1, D2, D3, CS, COMMIT; each accept advances one state.
REQ-015 HUNT_H0: accept of 0x4B -> HUNT_H1; any other byte stays.
REQ-016 HUNT_H1: 0x4C -> CH; 0x4B stays HUNT_H1; other -> HUNT_H0; no frame_err in HUNT states.
REQ-017 SHALL compute CS check as XOR of CH, D0, D1, D2, D3; compare to the CS byte.
REQ-018 On CS accept (cycle N) with match and CH < NUM_CH: go COMMIT; at N+1 ch_data = payload and ch_wr[CH] = 1 for one cycle; HUNT_H0 at N+2.
REQ-019 On CS mismatch or CH >= NUM_CH: frame_err = 1 at N+1, err_cnt +1, no ch_wr, -> HUNT_H0; ch_data unchanged.
REQ-020 ch_data SHALL change only in COMMIT and hold between commits.
REQ-021 An accept arriving in COMMIT SHALL be evaluated with HUNT_H0 rules.
REQ-022 err_cnt SHALL saturate at 255; simultaneous error sources SHALL count once.

Reset
REQ-023 On rst_n low: state HUNT_H0, rx_done_q 0, ch_data 0, ch_wr 0, busy 0, frame_err 0, err_cnt 0, timeout counter 0.
REQ-024 Reset mid-frame SHALL discard the partial frame with no ch_wr and no frame_err; the next frame after release SHALL be accepted normally.

Configuration
REQ-025 Macro UART_CMD_TIMEOUT_EN defined: counter clears on each accept, counts while busy; at TIMEOUT_CYC-1 with no accept -> frame_err pulse, err_cnt +1, -> HUNT_H0 (HUNT_H1 timeout returns silently, no error).
REQ-026 Macro undefined: no counter in RTL; partial frames wait indefinitely; all other behaviour identical.

Verification
REQ-027 4B 4C 01 78 56 34 12 09 -> ch_wr = 0010 one cycle, ch_data = 0x12345678, frame_err 0.
REQ-028 Same frame with CS 0x00 -> frame_err pulse, err_cnt 1, ch_wr 0, ch_data unchanged.
REQ-029 4B 4C 05 00 00 00 00 05 (NUM_CH = 4) -> frame_err, err_cnt +1, no ch_wr.
REQ-030 Garbage 00 4B 4B 4C 03 01 00 00 00 02 -> ch_wr = 1000, ch_data = 0x00000001.
REQ-031 UART_CMD_TIMEOUT_EN: 4B 4C 02 then idle TIMEOUT_CYC cycles -> frame_err, busy 0; undefined -> busy stays 1.
REQ-032 rst_n low after D1, release, full REQ-027 frame -> single correct commit, err_cnt 0; 300 bad frames -> err_cnt = 255.
